// File: rtl/cic_pkg.sv
// Shared definitions for the CIC compensation FIR.
//   state_t        : FSM encoding {IDLE, MAC, ROUND, OUT}
//   COEF_FRAC_DEF  : default coefficient fractional bits (Q5)
//   NTAPS_DEF      : default tap count
//   KERNEL         : 7-tap symmetric inverse-sinc kernel, sums to 32 (DC gain 1)
package cic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int COEF_FRAC_DEF = 5;
    localparam int NTAPS_DEF     = 7;
    localparam int COEFW_DEF     = 8;

    // h[k] multiplies x[n-k]; value = h/32.
    localparam logic signed [COEFW_DEF-1:0] KERNEL [NTAPS_DEF] = '{
        -8'sd2, 8'sd4, -8'sd10, 8'sd48, -8'sd10, 8'sd4, -8'sd2
    };

endpackage

// File: rtl/cic_comp_coef_rom.sv
// Combinational coefficient ROM: tap index -> kernel coefficient.
// Ports:
//   tap   in   TAPW       tap index 0..NTAPS-1
//   coef  out  COEFWIDTH  signed coefficient (0 for out-of-range index)
module cic_comp_coef_rom
    import cic_pkg::*;
#(
    parameter int NTAPS     = NTAPS_DEF,
    parameter int COEFWIDTH = COEFW_DEF,
    parameter int TAPW      = $clog2(NTAPS)
) (
    input  logic        [TAPW-1:0]      tap,
    output logic signed [COEFWIDTH-1:0] coef
);

    always_comb begin
        coef = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (tap == TAPW'(i)) coef = COEFWIDTH'(KERNEL[i]);
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// CIC compensation FIR: 7-tap symmetric inverse-sinc filter, time-multiplexed
// over a single multiplier/accumulator. One sample is processed per strobe:
// IDLE (accept) -> MAC x NTAPS -> ROUND -> OUT, i.e. NTAPS+3 cycles per sample.
// Optional build macro:
//   CIC_COMP_SAT_EN  defined   : rounded result clamps to the output range
//                    undefined : rounded result wraps to its low INPUTWIDTH bits
// Ports:
//   clk        in   1           clock
//   rst_n      in   1           synchronous reset, active-low
//   in_data    in   INPUTWIDTH  signed sample from the CIC
//   in_valid   in   1           sample strobe
//   out_data   out  INPUTWIDTH  filtered sample, held between strobes
//   out_valid  out  1           one-cycle strobe, out_data new this cycle
//   busy       out  1           sample in flight (FSM not IDLE)
//   overrun    out  1           sticky: a strobe was dropped
module cic_comp_fir
    import cic_pkg::*;
#(
    parameter int INPUTWIDTH = 8,
    parameter int COEFWIDTH  = COEFW_DEF,
    parameter int COEF_FRAC  = COEF_FRAC_DEF,
    parameter int NTAPS      = NTAPS_DEF,
    parameter int ACCWIDTH   = INPUTWIDTH + COEFWIDTH + $clog2(NTAPS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [INPUTWIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic signed [INPUTWIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int TAPW  = $clog2(NTAPS);
    localparam int PRODW = INPUTWIDTH + COEFWIDTH;

    localparam logic signed [ACCWIDTH-1:0] HALF = ACCWIDTH'(1 << (COEF_FRAC - 1));
    localparam logic signed [ACCWIDTH-1:0] OMAX = ACCWIDTH'((1 << (INPUTWIDTH - 1)) - 1);
    localparam logic signed [ACCWIDTH-1:0] OMIN = ~OMAX;

    state_t state, state_nxt;

    logic        [TAPW-1:0]       wr_ptr;
    logic        [TAPW-1:0]       k;
    logic        [TAPW-1:0]       rd_ptr;
    logic signed [INPUTWIDTH-1:0] dline [NTAPS];
    logic signed [ACCWIDTH-1:0]   acc;

    logic signed [COEFWIDTH-1:0]  coef;
    logic signed [INPUTWIDTH-1:0] x_rd;
    logic signed [PRODW-1:0]      prod;
    logic signed [ACCWIDTH-1:0]   acc_rnd;
    logic signed [ACCWIDTH-1:0]   r;
    logic signed [INPUTWIDTH-1:0] rnd_out;
    logic                         accept;
    logic                         drop;

    cic_comp_coef_rom #(
        .NTAPS     (NTAPS),
        .COEFWIDTH (COEFWIDTH),
        .TAPW      (TAPW)
    ) u_rom (
        .tap  (k),
        .coef (coef)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MAC;
            MAC:     if (k == TAPW'(NTAPS - 1)) state_nxt = ROUND;
            ROUND:   state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A strobe landing on the OUT->IDLE edge is still seen in OUT, so it drops.
    always_comb begin
        busy   = (state != IDLE);
        accept = (state == IDLE) && in_valid;
        drop   = (state != IDLE) && in_valid;
    end

    // x[n-k] lives at (wr_ptr - k) mod NTAPS; wr_ptr still points at the
    // newest sample because it only advances in OUT.
    always_comb begin
        if (wr_ptr >= k) rd_ptr = wr_ptr - k;
        else             rd_ptr = wr_ptr + TAPW'(NTAPS) - k;
    end

    assign x_rd    = dline[rd_ptr];
    assign prod    = PRODW'(x_rd) * PRODW'(coef);
    assign acc_rnd = acc + HALF;
    assign r       = acc_rnd >>> COEF_FRAC;

    always_comb begin
`ifdef CIC_COMP_SAT_EN
        if (r > OMAX)      rnd_out = OMAX[INPUTWIDTH-1:0];
        else if (r < OMIN) rnd_out = OMIN[INPUTWIDTH-1:0];
        else               rnd_out = r[INPUTWIDTH-1:0];
`else
        rnd_out = r[INPUTWIDTH-1:0];
`endif
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            wr_ptr    <= '0;
            k         <= '0;
            acc       <= '0;
            for (int i = 0; i < NTAPS; i++) dline[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (drop) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dline[wr_ptr] <= in_data;
                        acc           <= '0;
                        k             <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + ACCWIDTH'(prod);
                    k   <= k + 1'b1;
                end
                // Result registered here so out_valid is high for the OUT cycle.
                ROUND: begin
                    out_data  <= rnd_out;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    wr_ptr <= (wr_ptr == TAPW'(NTAPS - 1)) ? '0 : wr_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
module tb_cic_comp_fir;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [7:0] in_data;
    logic              in_valid;
    logic signed [7:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    cic_comp_fir dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Strobe v before the next edge, wait for out_valid (bounded), capture the
    // output, sample out_valid one cycle later, then pad to 'spacing' edges.
    task automatic run_sample(input logic signed [7:0] v, input int spacing,
                              output logic signed [7:0] y, output int lat,
                              output logic vld_after);
        in_data  = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        y = out_data;
        @(negedge clk);
        vld_after = out_valid;
        repeat (spacing - lat - 1) @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset;
        chk_cnt++; if (out_data !== 8'sd0) $display("FAIL reset_out_data: got %0d expected 0", out_data); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else pass_cnt++;
    endtask

    task automatic test_impulse(input bit with_reset);
        int exp_y [8] = '{-4, 8, -20, 96, -20, 8, -4, 0};
        logic signed [7:0] y;
        int lat;
        logic va;
        if (with_reset) do_reset;
        for (int i = 0; i < 8; i++) begin
            run_sample((i == 0) ? 8'sd64 : 8'sd0, 16, y, lat, va);
            chk_cnt++; if (y !== 8'(exp_y[i])) $display("FAIL impulse_out[%0d]: got %0d expected %0d", i, y, exp_y[i]); else pass_cnt++;
            chk_cnt++; if (lat != 9) $display("FAIL impulse_latency[%0d]: got %0d expected 9", i, lat); else pass_cnt++;
            if (i == 0) begin
                chk_cnt++; if (va !== 1'b0) $display("FAIL impulse_pulse_width: got %b expected 0", va); else pass_cnt++;
            end
        end
    endtask

    task automatic test_rounding;
        int exp_y [7] = '{0, 1, -2, 12, -2, 1, 0};
        logic signed [7:0] y;
        int lat;
        logic va;
        do_reset;
        for (int i = 0; i < 7; i++) begin
            run_sample((i == 0) ? 8'sd8 : 8'sd0, 12, y, lat, va);
            chk_cnt++; if (y !== 8'(exp_y[i])) $display("FAIL rounding_out[%0d]: got %0d expected %0d", i, y, exp_y[i]); else pass_cnt++;
        end
    endtask

    task automatic test_dc;
        int exp_y [12] = '{-1, 1, -2, 13, 9, 11, 10, 10, 10, 10, 10, 10};
        logic signed [7:0] y;
        int lat;
        logic va;
        do_reset;
        for (int i = 0; i < 12; i++) begin
            run_sample(8'sd10, 12, y, lat, va);
            chk_cnt++; if (y !== 8'(exp_y[i])) $display("FAIL dc_out[%0d]: got %0d expected %0d", i, y, exp_y[i]); else pass_cnt++;
        end
    endtask

    task automatic test_saturation;
`ifdef CIC_COMP_SAT_EN
        int exp_y [10] = '{-8, 24, -64, 127, -128, 127, -128, 127, -128, 127};
`else
        int exp_y [10] = '{-8, 24, -64, -2, -39, 54, -63, 62, -63, 62};
`endif
        logic signed [7:0] y;
        int lat;
        logic va;
        do_reset;
        for (int i = 0; i < 10; i++) begin
            run_sample((i % 2 == 0) ? 8'sd127 : -8'sd128, 12, y, lat, va);
            chk_cnt++; if (y !== 8'(exp_y[i])) $display("FAIL saturation_out[%0d]: got %0d expected %0d", i, y, exp_y[i]); else pass_cnt++;
        end
    endtask

    task automatic test_overrun;
        logic signed [7:0] y, y_cap;
        int lat, pulses;
        logic va;
        do_reset;
        in_data = 8'sd64; in_valid = 1'b1;      // accepted at edge 0
        @(negedge clk); in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        @(negedge clk);
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL overrun_before: got %b expected 0", overrun); else pass_cnt++;
        in_data = 8'sd100; in_valid = 1'b1;     // lands at edge 3, mid-MAC
        @(negedge clk); in_valid = 1'b0; in_data = '0;
        pulses = 0; y_cap = '0;
        for (int c = 0; c < 25; c++) begin
            if (out_valid === 1'b1) begin pulses++; y_cap = out_data; end
            @(negedge clk);
        end
        chk_cnt++; if (pulses != 1) $display("FAIL overrun_pulses: got %0d expected 1", pulses); else pass_cnt++;
        chk_cnt++; if (y_cap !== -8'sd4) $display("FAIL overrun_first_out: got %0d expected -4", y_cap); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun); else pass_cnt++;
        run_sample(8'sd0, 12, y, lat, va);
        chk_cnt++; if (y !== 8'sd8) $display("FAIL overrun_history: got %0d expected 8", y); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", overrun); else pass_cnt++;
    endtask

    // Strobe on the OUT->IDLE edge is dropped; strobe one edge later is accepted.
    task automatic test_back_to_back;
        logic signed [7:0] y;
        int lat, pulses;
        logic va;
        do_reset;
        run_sample(8'sd64, 10, y, lat, va);
        chk_cnt++; if (y !== -8'sd4) $display("FAIL b2b_first: got %0d expected -4", y); else pass_cnt++;
        run_sample(8'sd0, 10, y, lat, va);      // accepted at edge 10
        chk_cnt++; if (y !== 8'sd8) $display("FAIL b2b_second: got %0d expected 8", y); else pass_cnt++;
        chk_cnt++; if (lat != 9) $display("FAIL b2b_latency: got %0d expected 9", lat); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_no_overrun: got %b expected 0", overrun); else pass_cnt++;

        do_reset;
        in_data = 8'sd64; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; in_data = '0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        chk_cnt++; if (lat != 9) $display("FAIL edge9_latency: got %0d expected 9", lat); else pass_cnt++;
        in_data = 8'sd64; in_valid = 1'b1;      // sampled while still in OUT
        @(negedge clk); in_valid = 1'b0; in_data = '0;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            if (out_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        chk_cnt++; if (pulses != 0) $display("FAIL edge9_dropped: got %0d pulses expected 0", pulses); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b1) $display("FAIL edge9_overrun: got %b expected 1", overrun); else pass_cnt++;
    endtask

    // Runs after a test that leaves out_data non-zero.
    task automatic test_reset_mid_mac;
        int pulses;
        in_data = 8'sd64; in_valid = 1'b1;      // edge 0
        @(negedge clk); in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        @(negedge clk);
        chk_cnt++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", busy); else pass_cnt++;
        rst_n = 1'b0;                           // edge 3
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        chk_cnt++; if (pulses != 0) $display("FAIL midrst_no_valid: got %0d expected 0", pulses); else pass_cnt++;
        chk_cnt++; if (out_data !== 8'sd0) $display("FAIL midrst_out_data: got %0d expected 0", out_data); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else pass_cnt++;
        test_impulse(1'b0);
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset;
        test_impulse(1'b1);
        test_rounding;
        test_dc;
        test_overrun;
        test_back_to_back;
        test_saturation;
        test_reset_mid_mac;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
